// File: rtl/seg7_debug_display_pkg.sv
// Shared constants and helpers for the board seven-segment debug display.
// Select codes match the board switch encoding.
package seg7_debug_display_pkg;

    localparam int DBG_W = 32;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        DBG_SEL_ALU = 2'd0,
        DBG_SEL_RD  = 2'd1,
        DBG_SEL_MEM = 2'd2,
        DBG_SEL_PC  = 2'd3
    } dbg_sel_e;

    function automatic logic [7:0] an_onehot(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg7_debug_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
// Reusable by any board display; b and d use lower-case shapes.
module hex_to_seg7
    import seg7_debug_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nib_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg7_debug_display.sv
// Scans one CPU debug bus as 8 hex digits on a common-anode display.
// The shown value is snapshotted once per frame so digits never tear.
module seg7_debug_display
    import seg7_debug_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DATA_WIDTH  = DBG_W
) (
    input  logic                  clk100MHz,
    input  logic                  rst,
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] regfile_rd_in,
    input  logic [DATA_WIDTH-1:0] data_memory_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic [7:0]            an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CW =
        (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    dbg_sel_e              sel_s1_q, sel_s2_q;
    dbg_sel_e              sel_snap_q, sel_snap_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            digit_q, digit_d;
    logic [DATA_WIDTH-1:0] snap_q, snap_d;
    logic [7:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick, frame_end;
    logic [3:0]            nib;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (digit_q == 3'd7);
    assign nib       = snap_q[{digit_q, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nib_i (nib),
        .seg_o (seg_d)
    );

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        digit_d    = tick ? digit_q + 3'd1 : digit_q;
        snap_d     = snap_q;
        sel_snap_d = sel_snap_q;
        if (frame_end) begin
            sel_snap_d = sel_s2_q;
            unique case (sel_s2_q)
                DBG_SEL_ALU: snap_d = alu_result_in;
                DBG_SEL_RD:  snap_d = regfile_rd_in;
                DBG_SEL_MEM: snap_d = data_memory_in;
                DBG_SEL_PC:  snap_d = pc_in;
            endcase
        end
        an_d = an_onehot(digit_q);
        // Decimal point on digit i flags source code i.
        dp_d = (digit_q != {1'b0, sel_snap_q});
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            sel_s1_q   <= DBG_SEL_ALU;
            sel_s2_q   <= DBG_SEL_ALU;
            sel_snap_q <= DBG_SEL_ALU;
            cnt_q      <= '0;
            digit_q    <= 3'd0;
            snap_q     <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            sel_s1_q   <= dbg_sel_e'(sel);
            sel_s2_q   <= sel_s1_q;
            sel_snap_q <= sel_snap_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_debug_display.sv
// Bench for seg7_debug_display: frame-table scoreboard at REFRESH_DIV=4
// plus a mid-frame reset sequence that also exercises REFRESH_DIV=1.
module tb_seg7_debug_display;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] mem;
        logic [31:0] alt;
        logic [31:0] pc;
        bit          tog;
        logic [31:0] exp;
    } rec_t;

    localparam int NREC = 6;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] alu, rd, mem, pc;
    logic [7:0]  an4, an1;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1;

    exp_t q4[$];
    exp_t q1[$];
    rec_t rec [NREC];
    int   total = 0;
    int   bad = 0;
    int   k = 0;

    always #5 clk = ~clk;

    seg7_debug_display #(.REFRESH_DIV(4)) dut4 (
        .clk100MHz      (clk),
        .rst            (rst),
        .sel            (sel),
        .alu_result_in  (alu),
        .regfile_rd_in  (rd),
        .data_memory_in (mem),
        .pc_in          (pc),
        .an             (an4),
        .seg            (seg4),
        .dp             (dp4)
    );

    seg7_debug_display #(.REFRESH_DIV(1)) dut1 (
        .clk100MHz      (clk),
        .rst            (rst),
        .sel            (sel),
        .alu_result_in  (alu),
        .regfile_rd_in  (rd),
        .data_memory_in (mem),
        .pc_in          (pc),
        .an             (an1),
        .seg            (seg1),
        .dp             (dp1)
    );

    task automatic chk(input string nm, input exp_t e,
                       input logic [7:0] a, input logic [6:0] s,
                       input logic p);
        total++;
        if ({a, s, p} !== {e.an, e.seg, e.dp}) begin
            bad++;
            $display("FAIL %s k=%0d got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                     nm, k, a, s, p, e.an, e.seg, e.dp);
        end
    endtask

    task automatic push_blank();
        exp_t e;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
        q4.push_back(e);
        q1.push_back(e);
    endtask

    task automatic push_frame(input bit fast, input logic [31:0] v,
                              input logic [1:0] s);
        exp_t e;
        for (int d = 0; d < 8; d++) begin
            e.an  = ~(8'h01 << d);
            e.seg = GLYPH[v[4*d +: 4]];
            e.dp  = (d != int'(s));
            if (fast) q1.push_back(e);
            else for (int r = 0; r < 4; r++) q4.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        k++;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("div4", e, an4, seg4, dp4);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("div1", e, an1, seg1, dp1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

    initial begin
        rec[0] = '{2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                   1'b0, 32'h0000_0000};
        rec[1] = '{2'd0, 32'h1234_ABCD, 32'h0, 32'h0, 32'h0, 32'h0,
                   1'b0, 32'h1234_ABCD};
        rec[2] = '{2'd3, 32'h1234_ABCD, 32'h0, 32'h0, 32'h0,
                   32'h0000_0040, 1'b0, 32'h0000_0040};
        rec[3] = '{2'd2, 32'h1234_ABCD, 32'h0, 32'h8A8A_F00F,
                   32'h5555_1234, 32'h40, 1'b1, 32'h8A8A_F00F};
        rec[4] = '{2'd2, 32'h1234_ABCD, 32'h0, 32'h0123_4567,
                   32'hFEDC_BA98, 32'h40, 1'b1, 32'h0123_4567};
        rec[5] = '{2'd1, 32'h1234_ABCD, 32'h89F0_5E76, 32'h0,
                   32'h0, 32'h40, 1'b0, 32'h89F0_5E76};

        rst = 1'b1; sel = 2'd0;
        alu = '0; rd = '0; mem = '0; pc = '0;
        repeat (3) push_blank();
        repeat (3) step();
        rst = 1'b0;
        k = 0;

        // Next record is driven mid-frame; it must only show a frame later.
        for (int f = 0; f < NREC; f++) begin
            push_frame(1'b0, rec[f].exp, rec[f].sel);
            for (int j = 1; j <= 32; j++) begin
                step();
                if (f + 1 < NREC) begin
                    if (j == 8) begin
                        sel = rec[f+1].sel;
                        alu = rec[f+1].alu;
                        rd  = rec[f+1].rd;
                        pc  = rec[f+1].pc;
                        mem = rec[f+1].mem;
                    end
                    if (rec[f+1].tog && j >= 8)
                        mem = k[0] ? rec[f+1].mem : rec[f+1].alt;
                end
            end
        end

        push_frame(1'b0, rec[NREC-1].exp, rec[NREC-1].sel);
        repeat (22) step();
        rst = 1'b1;
        sel = 2'd1;
        rd  = 32'hBEEF_0A17;
        q4.delete();
        q1.delete();
        repeat (2) push_blank();
        repeat (2) step();
        rst = 1'b0;
        k = 0;
        push_frame(1'b0, 32'h0, 2'd0);
        push_frame(1'b0, 32'hBEEF_0A17, 2'd1);
        push_frame(1'b1, 32'h0, 2'd0);
        repeat (3) push_frame(1'b1, 32'hBEEF_0A17, 2'd1);
        repeat (64) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
